// File: rtl/npu8_host_seq_if.sv
// Command, response and NPU register-bus signals of the host sequencer.
// master = sequencer side, slave = harness/NPU side.
interface npu8_host_seq_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [7:0]  CMD_ADR;
    logic [31:0] CMD_WDATA;
    logic [7:0]  ADR;
    logic        WR;
    logic        RD;
    logic [31:0] WDATA;
    logic [31:0] RDATA;
    logic        INT;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;
    logic        BUSY;

    modport master (
        input  CMD_VALID, CMD_OP, CMD_ADR, CMD_WDATA, RDATA, INT,
        output CMD_READY, ADR, WR, RD, WDATA, RSP_VALID, RSP_DATA, RSP_ERR, BUSY
    );
    modport slave (
        output CMD_VALID, CMD_OP, CMD_ADR, CMD_WDATA, RDATA, INT,
        input  CMD_READY, ADR, WR, RD, WDATA, RSP_VALID, RSP_DATA, RSP_ERR, BUSY
    );
endinterface

// File: rtl/npu8_host_seq.sv
// Host-side NPU8 register-bus sequencer: queued write / read / wait-for-INT commands.
// Define NPU8_HOST_TIMEOUT_EN to bound wait-for-INT by TIMEOUT cycles (RSP_ERR=1 on expiry).
module npu8_host_seq #(
    parameter int FIFO_DEPTH = 8,
    parameter int RD_LAT     = 1,
    parameter int TIMEOUT    = 100000
) (
    input logic             CLK,
    input logic             RESET,
    npu8_host_seq_if.master bus
);
    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAT      = 4'(RD_LAT);
    localparam logic [1:0]  OP_WR    = 2'd0;
    localparam logic [1:0]  OP_RD    = 2'd1;
    localparam logic [1:0]  OP_WAIT  = 2'd2;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 and at least 2");
        end
        if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
            $error("RD_LAT must be in 1..15");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("TIMEOUT must be positive");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, WAITINT} state_t;
    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  adr;
        logic [31:0] wdata;
    } cmd_t;

    state_t       state_q, state_d;
    cmd_t         mem_q [FIFO_DEPTH];
    cmd_t         mem_d [FIFO_DEPTH];
    cmd_t         head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]  count_q, count_d;
    logic         cmd_ready_q, cmd_ready_d;
    logic [1:0]   op_q, op_d;
    logic [7:0]   adr_q, adr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic         wr_q, wr_d, rd_q, rd_d;
    logic [3:0]   lat_q, lat_d;
    logic [31:0]  wcnt_q, wcnt_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [31:0]  rsp_data_q, rsp_data_d;
    logic         busy_q, busy_d;
    logic         push, pop;
`ifdef NPU8_HOST_TIMEOUT_EN
    localparam logic [31:0] TO32 = 32'(TIMEOUT);
    logic         rsp_err_q, rsp_err_d;
`endif

    // Ready is registered and ignores a same-cycle pop, so a full FIFO always refuses.
    assign push = bus.CMD_VALID && cmd_ready_q;
    assign pop  = (state_q == IDLE) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        op_d        = op_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        lat_d       = lat_q;
        wcnt_d      = wcnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef NPU8_HOST_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif

        if (push) begin
            mem_d[wr_ptr_q] = {bus.CMD_OP, bus.CMD_ADR, bus.CMD_WDATA};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
        cmd_ready_d = (count_d != FULL_CNT);

        case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d = head.op;
                    if (head.op == OP_WR || head.op == OP_RD) begin
                        adr_d   = head.adr;
                        wdata_d = head.wdata;
                        wr_d    = (head.op == OP_WR);
                        rd_d    = (head.op == OP_RD);
                        state_d = ACCESS;
                    end else if (head.op == OP_WAIT) begin
                        wcnt_d  = '0;
                        state_d = WAITINT;
                    end
                end
            end
            ACCESS: begin
                if (op_q == OP_RD) begin
                    lat_d   = 4'd1;
                    state_d = RWAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            RWAIT: begin
                if (lat_q == LAT) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.RDATA;
`ifdef NPU8_HOST_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            WAITINT: begin
                if (bus.INT) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = wcnt_q;
`ifdef NPU8_HOST_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end
`ifdef NPU8_HOST_TIMEOUT_EN
                else if (wcnt_q == TO32) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = TO32;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end
`endif
                else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (count_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            op_q        <= '0;
            adr_q       <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            lat_q       <= '0;
            wcnt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef NPU8_HOST_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            op_q        <= op_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            lat_q       <= lat_d;
            wcnt_q      <= wcnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
`ifdef NPU8_HOST_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign bus.CMD_READY = cmd_ready_q;
    assign bus.ADR       = adr_q;
    assign bus.WDATA     = wdata_q;
    assign bus.WR        = wr_q;
    assign bus.RD        = rd_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.BUSY      = busy_q;
`ifdef NPU8_HOST_TIMEOUT_EN
    assign bus.RSP_ERR   = rsp_err_q;
`else
    assign bus.RSP_ERR   = 1'b0;
`endif
endmodule

// File: tb/tb_npu8_host_seq.sv
// Directed bench for npu8_host_seq: NPU register/INT model, bus monitor, cycle-exact checks.
module tb_npu8_host_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    npu8_host_seq_if bus ();
    npu8_host_seq #(.FIFO_DEPTH(8), .RD_LAT(1), .TIMEOUT(20)) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   overlap = 0;
    int   int_at = 0;
    logic rd_prev = 1'b0;
    logic [7:0] rd_adr = 8'h0;
    ev_t  wr_ev[$];
    ev_t  rd_ev[$];
    ev_t  rsp_ev[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [7:0] a);
        case (a)
            8'h04:   return 32'hDEAD_BEEF;
            8'h08:   return 32'h0000_0001;
            default: return {24'h123400, a};
        endcase
    endfunction

    // NPU model: RDATA valid the cycle after RD; INT raised from cycle int_at on.
    always @(negedge clk) begin
        bus.INT   = (int_at != 0) && (cyc >= int_at);
        bus.RDATA = rd_prev ? reg_val(rd_adr) : 32'h0;
        rd_prev   = bus.RD;
        if (bus.RD) rd_adr = bus.ADR;
    end

    always @(posedge clk) begin
        #1;
        if (bus.WR && bus.RD) overlap++;
        if (bus.WR) wr_ev.push_back('{cyc: cyc, a: 32'(bus.ADR), d: bus.WDATA});
        if (bus.RD) rd_ev.push_back('{cyc: cyc, a: 32'(bus.ADR), d: 32'h0});
        if (bus.RSP_VALID) rsp_ev.push_back('{cyc: cyc, a: 32'(bus.RSP_ERR), d: bus.RSP_DATA});
    end

    task automatic push(input logic [1:0] op, input logic [7:0] adr, input logic [31:0] wd,
                        output bit acc);
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op;
        bus.CMD_ADR   = adr;
        bus.CMD_WDATA = wd;
        acc           = bus.CMD_READY;
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic clear_ev();
        wr_ev.delete();
        rd_ev.delete();
        rsp_ev.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int n_acc;
        bit acc;
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = 2'd0;
        bus.CMD_ADR   = 8'h0;
        bus.CMD_WDATA = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_cmd_ready", 32'(bus.CMD_READY), 1);
        chk("rst_adr",       32'(bus.ADR), 0);
        chk("rst_wr",        32'(bus.WR), 0);
        chk("rst_rd",        32'(bus.RD), 0);
        chk("rst_wdata",     bus.WDATA, 0);
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 0);
        chk("rst_rsp_data",  bus.RSP_DATA, 0);
        chk("rst_rsp_err",   32'(bus.RSP_ERR), 0);
        chk("rst_busy",      32'(bus.BUSY), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single write
        clear_ev();
        c0 = cyc;
        push(2'd0, 8'h10, 32'h0000_0123, acc);
        wait_to(c0 + 8);
        chk("wr_count", 32'(wr_ev.size()), 1);
        if (wr_ev.size() > 0) begin
            chk("wr_cycle", 32'(wr_ev[0].cyc - c0), 2);
            chk("wr_adr",   wr_ev[0].a, 32'h10);
            chk("wr_data",  wr_ev[0].d, 32'h123);
        end
        chk("wr_no_rd",  32'(rd_ev.size()), 0);
        chk("wr_no_rsp", 32'(rsp_ev.size()), 0);
        chk("wr_adr_hold", 32'(bus.ADR), 32'h10);

        // single read, RD_LAT=1
        clear_ev();
        c0 = cyc;
        push(2'd1, 8'h04, 32'h0, acc);
        wait_to(c0 + 8);
        chk("rd_count", 32'(rd_ev.size()), 1);
        if (rd_ev.size() > 0) chk("rd_cycle", 32'(rd_ev[0].cyc - c0), 2);
        chk("rd_rsp_count", 32'(rsp_ev.size()), 1);
        if (rsp_ev.size() > 0) begin
            chk("rd_rsp_cycle", 32'(rsp_ev[0].cyc - c0), 4);
            chk("rd_rsp_data",  rsp_ev[0].d, 32'hDEAD_BEEF);
            chk("rd_rsp_err",   rsp_ev[0].a, 0);
        end
        chk("rd_no_wr", 32'(wr_ev.size()), 0);

        // write START, wait INT (raised 50 cycles in), read status
        clear_ev();
        c0 = cyc;
        int_at = c0 + 54;
        push(2'd0, 8'h00, 32'h1, acc);
        push(2'd2, 8'h00, 32'h0, acc);
        push(2'd1, 8'h08, 32'h0, acc);
        wait_to(c0 + 59);
        chk("seq_busy_low", 32'(bus.BUSY), 0);
        int_at = 0;
        chk("seq_rsp_count", 32'(rsp_ev.size()), 2);
        if (rsp_ev.size() == 2) begin
            chk("seq_wait_cycle", 32'(rsp_ev[0].cyc - c0), 55);
            chk("seq_wait_data",  rsp_ev[0].d, 50);
            chk("seq_wait_err",   rsp_ev[0].a, 0);
            chk("seq_rd_cycle",   32'(rsp_ev[1].cyc - c0), 58);
            chk("seq_rd_data",    rsp_ev[1].d, 32'h1);
        end
        chk("seq_wr_count", 32'(wr_ev.size()), 1);
        repeat (3) @(negedge clk);

        // FIFO full behind a blocking wait-INT
        clear_ev();
        c0 = cyc;
        push(2'd2, 8'h00, 32'h0, acc);
        int_at = c0 + 14;
        repeat (2) @(negedge clk);
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 1) push(2'd1, 8'h40 + 8'(i), 32'(i), acc);
            else            push(2'd0, 8'h30 + 8'(i), 32'(i), acc);
            if (i < 8) n_acc += int'(acc);
            else       chk("full_ninth_refused", 32'(acc), 0);
        end
        chk("full_accepted", 32'(n_acc), 8);
        wait_to(c0 + 60);
        int_at = 0;
        chk("full_rsp_count", 32'(rsp_ev.size()), 5);
        if (rsp_ev.size() == 5) begin
            chk("full_wait_cycle", 32'(rsp_ev[0].cyc - c0), 15);
            chk("full_wait_data",  rsp_ev[0].d, 12);
            for (int k = 0; k < 4; k++)
                chk($sformatf("full_rd%0d_data", k), rsp_ev[k+1].d, {24'h123400, 8'h41 + 8'(2*k)});
        end
        chk("full_wr_count", 32'(wr_ev.size()), 4);
        if (wr_ev.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("full_wr%0d_adr", k),  wr_ev[k].a, 32'h30 + 32'(2*k));
                chk($sformatf("full_wr%0d_data", k), wr_ev[k].d, 32'(2*k));
            end
        end
        chk("full_busy_low", 32'(bus.BUSY), 0);
        repeat (3) @(negedge clk);

        // reset during RWAIT with three writes queued
        clear_ev();
        c0 = cyc;
        int_at = c0 + 6;
        push(2'd2, 8'h00, 32'h0, acc);
        push(2'd1, 8'h04, 32'h0, acc);
        push(2'd0, 8'h60, 32'h60, acc);
        push(2'd0, 8'h61, 32'h61, acc);
        push(2'd0, 8'h62, 32'h62, acc);
        wait_to(c0 + 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        int_at = 0;
        chk("rstmid_rd",        32'(bus.RD), 0);
        chk("rstmid_wr",        32'(bus.WR), 0);
        chk("rstmid_busy",      32'(bus.BUSY), 0);
        chk("rstmid_cmd_ready", 32'(bus.CMD_READY), 1);
        chk("rstmid_rsp_valid", 32'(bus.RSP_VALID), 0);
        wait_to(c0 + 25);
        if (rd_ev.size() > 0) chk("rstmid_rd_cycle", 32'(rd_ev[0].cyc - c0), 8);
        chk("rstmid_rd_count",  32'(rd_ev.size()), 1);
        chk("rstmid_rsp_count", 32'(rsp_ev.size()), 1);
        if (rsp_ev.size() > 0) chk("rstmid_wait_data", rsp_ev[0].d, 4);
        chk("rstmid_no_wr", 32'(wr_ev.size()), 0);
        chk("rstmid_idle_busy", 32'(bus.BUSY), 0);

`ifdef NPU8_HOST_TIMEOUT_EN
        // wait-INT timeout, following write still issues
        clear_ev();
        c0 = cyc;
        push(2'd2, 8'h00, 32'h0, acc);
        push(2'd0, 8'h50, 32'hAA, acc);
        wait_to(c0 + 30);
        chk("to_rsp_count", 32'(rsp_ev.size()), 1);
        if (rsp_ev.size() > 0) begin
            chk("to_rsp_cycle", 32'(rsp_ev[0].cyc - c0), 23);
            chk("to_rsp_err",   rsp_ev[0].a, 1);
            chk("to_rsp_data",  rsp_ev[0].d, 20);
        end
        chk("to_wr_count", 32'(wr_ev.size()), 1);
        if (wr_ev.size() > 0) begin
            chk("to_wr_cycle", 32'(wr_ev[0].cyc - c0), 24);
            chk("to_wr_adr",   wr_ev[0].a, 32'h50);
        end
`endif

        chk("wr_rd_exclusive", 32'(overlap), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/npu8_host_seq.md
Name: npu8_host_seq

Overview:
Host-side register-access sequencer: the initiator end of the NPU8 CPU register bus (ADR/WR/RD/WDATA/RDATA/INT).
- Accepts queued commands: register write, register read, wait-for-INT.
- Issues each command as a bus cycle toward the NPU, then returns read data and wait results on a response port.
- Used in the sim/FPGA harness to program M1POS/OP/gains, kick START and wait for FINISH/INT without a real CPU.

Parameters:
FIFO_DEPTH, 8, command FIFO entries; power of 2, minimum 2.
RD_LAT, 1, cycles from the RD-asserted cycle to the RDATA sample; range 1..15.
TIMEOUT, 100000, wait-for-INT cycle limit; used only with NPU8_HOST_TIMEOUT_EN.

Ports:
CLK input 1 clock; all logic on rising edge.
RESET input 1 synchronous active-high reset.
CMD_VALID input 1 command offered.
CMD_READY output 1 FIFO not full.
CMD_OP input 2 0 = write, 1 = read, 2 = wait INT, 3 = reserved, treated as a no-op.
CMD_ADR input 8 register address.
CMD_WDATA input 32 write data.
ADR output 8 bus address to the NPU.
WR output 1 one-cycle write strobe.
RD output 1 one-cycle read strobe.
WDATA output 32 bus write data.
RDATA input 32 bus read data.
INT input 1 NPU interrupt, level.
RSP_VALID output 1 one-cycle response pulse.
RSP_DATA output 32 read data, or wait cycle count.
RSP_ERR output 1 wait timed out; valid with RSP_VALID.
BUSY output 1 FIFO non-empty or state != IDLE.

Behaviour:
- Reset values: CMD_READY=1, ADR=0, WR=0, RD=0, WDATA=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, BUSY=0, FIFO empty, state IDLE, counters 0.
- Reset asserted mid-operation: the next edge aborts the command in flight. WR/RD drop, the FIFO is flushed, and no response is emitted.
- FIFO push: on CMD_VALID & CMD_READY.
  - CMD_READY = !full, registered, and not pop-aware. A push is refused when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO are both performed; the count is unchanged.
- State machine: IDLE, ACCESS, RWAIT, WAITINT.
- IDLE: if the FIFO is non-empty, pop the head.
  - Write or read: register ADR and WDATA and go to ACCESS.
  - Wait INT: clear the wait counter and go to WAITINT.
  - Op 3: discard and stay in IDLE.
- ACCESS, exactly one cycle:
  - Write: WR=1 with ADR/WDATA stable, then go to IDLE.
  - Read: RD=1, then go to RWAIT with lat_cnt=1.
  - WR and RD are never high together.
- RWAIT: RDATA is sampled on the edge ending the cycle in which lat_cnt == RD_LAT. In that same edge RSP_DATA <= RDATA and RSP_VALID <= 1 for one cycle, and the state goes to IDLE. Otherwise lat_cnt increments.
- Timing:
  - A write pops at cycle t; WR is high at t+1; the next pop happens at t+2.
  - A read pops at t; RD is high at t+1; RSP_VALID is high at t+2+RD_LAT.
- ADR/WDATA hold their last value when no strobe is active.
- WAITINT:
  - Each cycle with INT=0, the wait counter increments, saturating at 32'hFFFFFFFF.
  - When INT=1 is sampled: RSP_VALID=1, RSP_DATA = counter value (0 if INT is already high in the first WAITINT cycle), RSP_ERR=0, then go to IDLE.
  - INT is level-sensitive. The sequencer does not clear it; clearing is done by a following write command.
- Only one command is outstanding on the bus at a time. Response order equals command order. Writes and op-3 produce no response.
- BUSY drops in the cycle after the last command returns to IDLE with the FIFO empty.

Optional Feature:
NPU8_HOST_TIMEOUT_EN
- Defined: in WAITINT, if the counter reaches TIMEOUT with INT still 0, emit RSP_VALID=1, RSP_ERR=1, RSP_DATA=TIMEOUT, and go to IDLE. The remaining FIFO commands continue.
- Not defined: WAITINT waits indefinitely. RSP_ERR is tied 0 and no timeout comparator is built.

Test Plan:
- Write: push op0 ADR=0x10, WDATA=0x0000_0123 -> exactly one cycle with WR=1, ADR=0x10, WDATA=0x123; RD=0 throughout; no RSP_VALID.
- Read, RD_LAT=1: push op1 ADR=0x04; NPU model drives RDATA=0xDEAD_BEEF the cycle after RD -> RSP_VALID one cycle, 3 cycles after the pop; RSP_DATA=0xDEADBEEF.
- Sequence: write START, wait INT, read status. Model raises INT 50 cycles into WAITINT -> wait RSP_DATA=50, then the read response in order; BUSY low after the final response.
- FIFO full, FIFO_DEPTH=8, with a wait INT at the head and INT=0: push 9 commands -> 8 accepted; CMD_READY=0 on the 9th; raise INT -> the queue drains in order with no loss.
- Reset mid-read (RESET high during RWAIT, 3 queued entries) -> next cycle RD/WR=0, BUSY=0, CMD_READY=1; no RSP_VALID ever appears for the aborted read.
- With NPU8_HOST_TIMEOUT_EN and TIMEOUT=20, INT held 0: wait INT -> RSP_VALID with RSP_ERR=1 and RSP_DATA=20; the following queued write still issues.
